// File: rtl/ahbl_arbiter_2.sv
// ahbl_arbiter_2: two-master AHB-Lite arbiter/multiplexer.
// Address/control is muxed by the address-phase owner and HWDATA by the
// data-phase owner. HRDATA is broadcast to both masters. A requesting
// non-owner is stalled through its own HREADY. Ownership only changes
// when the current owner drives IDLE, so a handover never orphans a
// data phase.
module ahbl_arbiter_2 #(
    parameter int DEFAULT_MASTER = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    output logic        HMASTER
);

    localparam logic DEF_MASTER = DEFAULT_MASTER[0];

    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic [2:0]  hsize;
        logic        hwrite;
    } ahb_ctrl_t;

    ahb_ctrl_t [1:0]        ctrl;
    logic      [1:0][31:0]  wdata;
    logic      [1:0]        req;
    logic      [1:0]        rdy;
    logic                   owner;
    logic                   downer;
    logic                   owner_nxt;

    assign ctrl[0]  = {M0_HADDR, M0_HTRANS, M0_HSIZE, M0_HWRITE};
    assign ctrl[1]  = {M1_HADDR, M1_HTRANS, M1_HSIZE, M1_HWRITE};
    assign wdata[0] = M0_HWDATA;
    assign wdata[1] = M1_HWDATA;

    // NONSEQ/SEQ request; BUSY (01) deliberately counts as no request
    assign req[0] = M0_HTRANS[1];
    assign req[1] = M1_HTRANS[1];

    // Shared-bus muxes: address phase follows owner, write data follows downer
    always_comb begin
        HADDR   = ctrl[owner].haddr;
        HTRANS  = ctrl[owner].htrans;
        HSIZE   = ctrl[owner].hsize;
        HWRITE  = ctrl[owner].hwrite;
        HWDATA  = wdata[downer];
        HMASTER = owner;
    end

    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;

    // Owner gets the bus ready; a requesting non-owner is held off
    for (genvar m = 0; m < 2; m++) begin : g_rdy
        assign rdy[m] = (owner == 1'(m)) ? HREADY : ~req[m];
    end
    assign M0_HREADY = rdy[0];
    assign M1_HREADY = rdy[1];

    // Handover only when the owner is IDLE and the other master is asking
    always_comb begin
        owner_nxt = owner;
        if (ctrl[owner].htrans == 2'b00 && req[~owner])
            owner_nxt = ~owner;
    end

    // Owner/downer advance only on accepted cycles; wait states freeze both
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner  <= DEF_MASTER;
            downer <= DEF_MASTER;
        end else if (HREADY) begin
            downer <= owner;
            owner  <= owner_nxt;
        end
    end

endmodule

// File: tb/tb_ahbl_arbiter_2.sv
// Directed testbench for ahbl_arbiter_2. The driver applies one vector per
// cycle and queues the hand-computed bus response; a monitor on the falling
// edge pops and compares. A second instance with DEFAULT_MASTER=1 shares the
// inputs and is checked only across the reset cycles.
module tb_ahbl_arbiter_2;

    typedef struct {
        string       name;
        logic        hm;
        logic [1:0]  tr;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        r0;
        logic        r1;
        logic [31:0] rd;
        bit          cdm1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] M0_HADDR = '0, M1_HADDR = '0, M0_HWDATA = '0, M1_HWDATA = '0;
    logic [1:0]  M0_HTRANS = '0, M1_HTRANS = '0;
    logic [2:0]  M0_HSIZE = 3'd2, M1_HSIZE = 3'd1;
    logic        M0_HWRITE = 1'b1, M1_HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = '0;

    logic        M0_HREADY, M1_HREADY, HWRITE, HMASTER;
    logic [31:0] M0_HRDATA, M1_HRDATA, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    logic        d_M0_HREADY, d_M1_HREADY, d_HWRITE, d_HMASTER;
    logic [31:0] d_M0_HRDATA, d_M1_HRDATA, d_HADDR, d_HWDATA;
    logic [1:0]  d_HTRANS;
    logic [2:0]  d_HSIZE;

    always #5 HCLK = ~HCLK;

    ahbl_arbiter_2 #(.DEFAULT_MASTER(0)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE),
        .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
        .M0_HRDATA(M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE),
        .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
        .M1_HRDATA(M1_HRDATA),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HMASTER(HMASTER)
    );

    ahbl_arbiter_2 #(.DEFAULT_MASTER(1)) dut_dm1 (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE),
        .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(d_M0_HREADY),
        .M0_HRDATA(d_M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE),
        .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(d_M1_HREADY),
        .M1_HRDATA(d_M1_HRDATA),
        .HADDR(d_HADDR), .HTRANS(d_HTRANS), .HSIZE(d_HSIZE), .HWRITE(d_HWRITE),
        .HWDATA(d_HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HMASTER(d_HMASTER)
    );

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and queue the expected bus response
    task automatic step(input string nm, input bit rst,
                        input logic [1:0] t0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [1:0] t1, input logic [31:0] a1, input logic [31:0] d1,
                        input bit hrdy, input logic [31:0] hrd,
                        input logic ehm, input logic [1:0] etr, input logic [31:0] ead,
                        input logic [31:0] ewd, input logic er0, input logic er1,
                        input bit cdm1);
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESET = rst;
        M0_HTRANS = t0; M0_HADDR = a0; M0_HWDATA = d0;
        M1_HTRANS = t1; M1_HADDR = a1; M1_HWDATA = d1;
        HREADY = hrdy; HRDATA = hrd;
        e.name = nm; e.hm = ehm; e.tr = etr; e.ad = ead; e.wd = ewd;
        e.r0 = er0; e.r1 = er1; e.rd = hrd; e.cdm1 = cdm1;
        q.push_back(e);
    endtask

    // Monitor: compare the settled outputs mid-cycle against the queued record
    initial begin
        forever begin
            @(negedge HCLK);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk(e.name, "HMASTER",   32'(HMASTER),   32'(e.hm));
                chk(e.name, "HTRANS",    32'(HTRANS),    32'(e.tr));
                chk(e.name, "HADDR",     HADDR,          e.ad);
                chk(e.name, "HWDATA",    HWDATA,         e.wd);
                chk(e.name, "M0_HREADY", 32'(M0_HREADY), 32'(e.r0));
                chk(e.name, "M1_HREADY", 32'(M1_HREADY), 32'(e.r1));
                chk(e.name, "HSIZE",     32'(HSIZE),     e.hm ? 32'd1 : 32'd2);
                chk(e.name, "HWRITE",    32'(HWRITE),    e.hm ? 32'd0 : 32'd1);
                chk(e.name, "M0_HRDATA", M0_HRDATA,      e.rd);
                chk(e.name, "M1_HRDATA", M1_HRDATA,      e.rd);
                if (e.cdm1) begin
                    chk(e.name, "DM1_HMASTER",   32'(d_HMASTER),   32'd1);
                    chk(e.name, "DM1_HTRANS",    32'(d_HTRANS),    32'd0);
                    chk(e.name, "DM1_M0_HREADY", 32'(d_M0_HREADY), 32'd1);
                    chk(e.name, "DM1_M1_HREADY", 32'(d_M1_HREADY), 32'd1);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        // name  rst t0 a0 d0 | t1 a1 d1 | hrdy hrd | hm tr haddr hwdata r0 r1 dm1
        step("rst1", 1, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 1, 1, 1);
        step("rst2", 1, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 1, 1, 1);

        // M0 sole requester: single write
        step("wr_addr", 0, 2'b10, 32'h4000_0000, 0, 2'b00, 0, 0, 1, 0,
             0, 2'b10, 32'h4000_0000, 0, 1, 1, 0);
        step("wr_data", 0, 2'b00, 0, 32'h1234_5678, 2'b00, 0, 0, 1, 0,
             0, 2'b00, 0, 32'h1234_5678, 1, 1, 0);

        // M0 4-beat burst while M1 holds NONSEQ
        step("bst1", 0, 2'b10, 32'h4000_0100, 0, 2'b10, 32'h4001_0000, 0, 1, 0,
             0, 2'b10, 32'h4000_0100, 0, 1, 0, 0);
        step("bst2", 0, 2'b11, 32'h4000_0104, 32'hA000_0000, 2'b10, 32'h4001_0000, 0, 1, 0,
             0, 2'b11, 32'h4000_0104, 32'hA000_0000, 1, 0, 0);
        step("bst3", 0, 2'b11, 32'h4000_0108, 32'hA000_0001, 2'b10, 32'h4001_0000, 0, 1, 0,
             0, 2'b11, 32'h4000_0108, 32'hA000_0001, 1, 0, 0);
        step("bst4", 0, 2'b11, 32'h4000_010C, 32'hA000_0002, 2'b10, 32'h4001_0000, 0, 1, 0,
             0, 2'b11, 32'h4000_010C, 32'hA000_0002, 1, 0, 0);
        step("bst_idle", 0, 2'b00, 0, 32'hA000_0003, 2'b10, 32'h4001_0000, 0, 1, 0,
             0, 2'b00, 0, 32'hA000_0003, 1, 0, 0);
        step("bst_sw", 0, 2'b00, 0, 0, 2'b10, 32'h4001_0000, 32'h5555_0000, 1, 0,
             1, 2'b10, 32'h4001_0000, 0, 1, 1, 0);
        step("bst_m1d", 0, 2'b00, 0, 0, 2'b00, 0, 32'hBEEF_0001, 1, 0,
             1, 2'b00, 0, 32'hBEEF_0001, 1, 1, 0);

        // Wait states on M0's last data phase while M1 waits
        step("ws_req", 0, 2'b10, 32'h4000_0200, 0, 2'b00, 0, 0, 1, 0,
             1, 2'b00, 0, 0, 0, 1, 0);
        step("ws_addr", 0, 2'b10, 32'h4000_0200, 0, 2'b10, 32'h4001_0400, 0, 1, 0,
             0, 2'b10, 32'h4000_0200, 0, 1, 0, 0);
        step("ws_w1", 0, 2'b00, 0, 32'hC0C0_C0C0, 2'b10, 32'h4001_0400, 0, 0, 0,
             0, 2'b00, 0, 32'hC0C0_C0C0, 0, 0, 0);
        step("ws_w2", 0, 2'b00, 0, 32'hC0C0_C0C0, 2'b10, 32'h4001_0400, 0, 0, 0,
             0, 2'b00, 0, 32'hC0C0_C0C0, 0, 0, 0);
        step("ws_w3", 0, 2'b00, 0, 32'hC0C0_C0C0, 2'b10, 32'h4001_0400, 0, 0, 0,
             0, 2'b00, 0, 32'hC0C0_C0C0, 0, 0, 0);
        step("ws_done", 0, 2'b00, 0, 32'hC0C0_C0C0, 2'b10, 32'h4001_0400, 0, 1, 0,
             0, 2'b00, 0, 32'hC0C0_C0C0, 1, 0, 0);
        step("ws_sw", 0, 2'b00, 0, 32'hC0C0_C0C0, 2'b10, 32'h4001_0400, 0, 1, 0,
             1, 2'b10, 32'h4001_0400, 32'hC0C0_C0C0, 1, 1, 0);
        step("ws_park", 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0,
             1, 2'b00, 0, 0, 1, 1, 0);

        // Ping-pong single reads; M0 re-requests right after its own release
        step("pp1", 0, 2'b10, 32'h4000_0300, 0, 2'b00, 0, 0, 1, 32'h1111_0000,
             1, 2'b00, 0, 0, 0, 1, 0);
        step("pp2", 0, 2'b10, 32'h4000_0300, 0, 2'b00, 0, 0, 1, 32'h2222_0000,
             0, 2'b10, 32'h4000_0300, 0, 1, 1, 0);
        step("pp3", 0, 2'b00, 0, 0, 2'b10, 32'h4001_0500, 0, 1, 32'h3333_0000,
             0, 2'b00, 0, 0, 1, 0, 0);
        step("pp4", 0, 2'b10, 32'h4000_0308, 0, 2'b10, 32'h4001_0500, 0, 1, 32'h4444_0000,
             1, 2'b10, 32'h4001_0500, 0, 0, 1, 0);
        step("pp5", 0, 2'b10, 32'h4000_0308, 0, 2'b00, 0, 0, 1, 32'h5555_0000,
             1, 2'b00, 0, 0, 0, 1, 0);
        step("pp6", 0, 2'b10, 32'h4000_0308, 0, 2'b00, 0, 0, 1, 32'h6666_0000,
             0, 2'b10, 32'h4000_0308, 0, 1, 1, 0);
        step("pp7", 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 32'h7777_0000,
             0, 2'b00, 0, 0, 1, 1, 0);

        // Reset while M1 owns mid-burst
        step("rb1", 0, 2'b00, 0, 0, 2'b10, 32'h4001_0600, 0, 1, 0,
             0, 2'b00, 0, 0, 1, 0, 0);
        step("rb2", 0, 2'b00, 0, 0, 2'b10, 32'h4001_0600, 0, 1, 0,
             1, 2'b10, 32'h4001_0600, 0, 1, 1, 0);
        step("rb_rst", 1, 2'b00, 0, 0, 2'b11, 32'h4001_0604, 32'hDD00_0000, 1, 0,
             1, 2'b11, 32'h4001_0604, 32'hDD00_0000, 1, 1, 0);
        step("rb_post", 0, 2'b00, 0, 0, 2'b11, 32'h4001_0604, 32'hDD00_0000, 1, 0,
             0, 2'b00, 0, 0, 1, 0, 0);
        step("rb_regain", 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0,
             1, 2'b00, 0, 0, 1, 1, 0);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge HCLK);
            wait_cyc++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        @(posedge HCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahbl_arbiter_2.md
Name: ahbl_arbiter_2

Overview:
- Two-master AHB-Lite bus arbiter/multiplexer.
- Lets two ahbl_master-style initiators (M0, M1) share one AHB-Lite bus. That bus feeds the existing ahbl_splitter_3, its slaves and the peripheral.
- Muxes address/control by address-phase owner and HWDATA by data-phase owner, and broadcasts HRDATA.
- Stalls the non-owning requester with a per-master HREADY.

Parameters:
- DEFAULT_MASTER, 0: master owning (parked on) the bus after reset; legal values 0 or 1.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge
- HRESET  in  1  synchronous, active-high reset
- M0_HADDR  in  32  master 0 address
- M0_HTRANS  in  2  master 0 transfer type (00 IDLE, 10 NONSEQ, 11 SEQ; 01 BUSY is treated as non-requesting)
- M0_HSIZE  in  3  master 0 size
- M0_HWRITE  in  1  master 0 direction
- M0_HWDATA  in  32  master 0 write data
- M0_HREADY  out  1  ready returned to master 0
- M0_HRDATA  out  32  read data to master 0
- M1_HADDR, M1_HTRANS, M1_HSIZE, M1_HWRITE, M1_HWDATA, M1_HREADY, M1_HRDATA: same as M0, for master 1
- HADDR  out  32  shared bus address
- HTRANS  out  2  shared bus transfer type
- HSIZE  out  3  shared bus size
- HWRITE  out  1  shared bus direction
- HWDATA  out  32  shared bus write data
- HREADY  in  1  bus ready (from splitter)
- HRDATA  in  32  bus read data (from splitter)
- HMASTER  out  1  current address-phase owner

Behaviour:
- State:
  - owner (1 bit): address-phase owner.
  - downer (1 bit): data-phase owner.
- Reset (HRESET=1 at a clock edge): owner=DEFAULT_MASTER, downer=DEFAULT_MASTER. With inputs idle this gives HMASTER=DEFAULT_MASTER, HTRANS=00 and M0_HREADY=M1_HREADY=1. Reset mid-transfer abandons any data phase; no pending state survives.
- Request: master m requests when Mm_HTRANS[1]=1.
- Address mux (combinational from owner): HADDR/HTRANS/HSIZE/HWRITE = owner's inputs. The non-owner's inputs never reach the bus.
- Write-data mux: HWDATA = downer's HWDATA.
- Read data: M0_HRDATA = M1_HRDATA = HRDATA.
- Per-master ready:
  - owner sees Mm_HREADY = HREADY.
  - non-owner sees Mm_HREADY = 0 while requesting, else 1.
  - A stalled master holds its address/control, as AHB-Lite requires.
- Data-phase tracking: when HREADY=1, downer <= owner. When HREADY=0, downer holds.
- Handover: evaluated only in cycles with HREADY=1.
  - If owner's HTRANS=00 (IDLE) and the other master requests, owner <= other at the next edge.
  - Otherwise owner holds. Parking: an idle bus stays with the last owner.
- No handover inside a burst or on back-to-back NONSEQs: the owner keeps the bus until it drives IDLE. Starvation by a never-idle master is by design.
- HREADY=0 cycles: owner and downer both frozen; all mux selects unchanged.
- Handover latency: the requester's NONSEQ reaches the bus one cycle after the owner's IDLE cycle (with HREADY=1). The requester's first accepted address cycle is therefore at most 1 cycle after owner release.
- Simultaneous case: the owner issuing IDLE and the other requesting in the same cycle gives a switch. The owner re-requesting in the very next cycle is then stalled (its HREADY=0) until it regains ownership.
- The old owner's last real data phase completes in the IDLE cycle, so a switch never orphans a data phase. HWDATA of that phase comes from the old owner via downer.
- No combinational path from Mm_* inputs to HREADY. There is a combinational path from HREADY to Mm_HREADY.

Test Plan:
- Reset, DEFAULT_MASTER=1, HRESET held 2 cycles: HMASTER=1, HTRANS=00, M0_HREADY=M1_HREADY=1.
- M0 sole requester, write 0x4000_0000 data 0x1234_5678 with DEFAULT_MASTER=0: HADDR=0x4000_0000 in cycle 1 and HWDATA=0x1234_5678 in cycle 2. M1 is never stalled.
- M0 owner running a 4-beat SEQ burst while M1 holds NONSEQ 0x4001_0000:
  - M1_HREADY=0 throughout the burst and for M0's IDLE cycle.
  - HMASTER=1 the cycle after M0's IDLE.
  - HADDR=0x4001_0000 with HTRANS=10 that cycle.
- Slave inserts 3 wait states (HREADY=0) on M0's last data phase while M1 is waiting:
  - owner/downer are frozen.
  - HWDATA stays M0's data for all 3 cycles.
  - the switch happens only after HREADY=1 with M0 IDLE.
- Ping-pong, each master issuing single NONSEQ reads followed by IDLE: ownership alternates every 2 cycles. M0_HRDATA=M1_HRDATA=HRDATA every cycle, and each master samples data only when its own HREADY=1.
- Assert HRESET while M1 owns the bus mid-burst: next cycle owner=downer=DEFAULT_MASTER and M1_HREADY=0 if M1 is still requesting.
